// File: rtl/rng_candidate_sampler.sv
`timescale 1ns/1ps
// rng_candidate_sampler: consumer of the free-running 32-bit keygen LFSR.
// Waits for the user's start press, then on request XOR-whitens two LFSR
// words taken GAP cycles apart into an odd, full-width candidate. The
// candidate is offered over valid/ready. A repeat of the last accepted
// candidate can optionally be rejected, so that p differs from q.
//
// state | meaning
// IDLE  | no transaction; capture first sample on req once seeded
// WAIT  | counting down GAP cycles to the second sample (resample on dup)
// VALID | candidate presented, held until cand_ready
module rng_candidate_sampler #(
    parameter int WIDTH = 16,
    parameter int GAP   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      rng_in,
    output logic             lfsr_en,
    output logic             seeded,
    input  logic             req,
    input  logic             reject_dup,
    output logic [WIDTH-1:0] cand,
    output logic             cand_valid,
    input  logic             cand_ready,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, WAIT, VALID} state_t;

    localparam logic [7:0] CNT_LOAD = 8'(GAP - 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] s1, s1_nx;
    logic [WIDTH-1:0] prev, prev_nx;
    logic [WIDTH-1:0] cand_nx;
    logic [WIDTH-1:0] w, nc;
    logic [7:0]       cnt, cnt_nx;
    logic             valid_nx;

    // Upper LFSR bits beyond WIDTH carry no information for the candidate.
    logic rng_unused;
    assign rng_unused = ^rng_in;

    assign busy = (state != IDLE);

    // Whitening and shaping: force MSB (full width) and LSB (odd).
    always_comb begin
        w             = s1 ^ rng_in[WIDTH-1:0];
        nc            = w;
        nc[0]         = 1'b1;
        nc[WIDTH-1]   = 1'b1;
    end

    // LFSR runs from the first edge after reset; seeded latches the start press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_en <= 1'b0;
            seeded  <= 1'b0;
        end else begin
            lfsr_en <= 1'b1;
            if (start)
                seeded <= 1'b1;
        end
    end

    // Next-state and datapath update for the sampling transaction.
    always_comb begin
        state_nx = state;
        s1_nx    = s1;
        cnt_nx   = cnt;
        cand_nx  = cand;
        valid_nx = cand_valid;
        prev_nx  = prev;
        case (state)
            IDLE: begin
                if (req && seeded) begin
                    s1_nx    = rng_in[WIDTH-1:0];
                    cnt_nx   = CNT_LOAD;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (cnt != 8'd0) begin
                    cnt_nx = cnt - 8'd1;
                end else if (reject_dup && (nc == prev)) begin
                    s1_nx  = rng_in[WIDTH-1:0];
                    cnt_nx = CNT_LOAD;
                end else begin
                    cand_nx  = nc;
                    valid_nx = 1'b1;
                    state_nx = VALID;
                end
            end
            VALID: begin
                if (cand_ready) begin
                    prev_nx  = cand;
                    valid_nx = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            s1         <= '0;
            cnt        <= '0;
            cand       <= '0;
            cand_valid <= 1'b0;
            prev       <= '0;
        end else begin
            state      <= state_nx;
            s1         <= s1_nx;
            cnt        <= cnt_nx;
            cand       <= cand_nx;
            cand_valid <= valid_nx;
            prev       <= prev_nx;
        end
    end

endmodule

// File: tb/tb_rng_candidate_sampler.sv
`timescale 1ns/1ps
// Bench for rng_candidate_sampler (WIDTH=16, GAP=4): transaction-level model
// checked every cycle, plus directed vectors with hand-computed values.
module tb_rng_candidate_sampler;

    localparam int WIDTH = 16;
    localparam int GAP   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      rng_in = 32'h0;
    logic             lfsr_en, seeded, cand_valid, busy;
    logic             req = 1'b0;
    logic             reject_dup = 1'b0;
    logic             cand_ready = 1'b0;
    logic [WIDTH-1:0] cand;

    int checks = 0;
    int errors = 0;

    rng_candidate_sampler #(.WIDTH(WIDTH), .GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rng_in(rng_in),
        .lfsr_en(lfsr_en), .seeded(seeded), .req(req), .reject_dup(reject_dup),
        .cand(cand), .cand_valid(cand_valid), .cand_ready(cand_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Candidate rule in plain arithmetic: low WIDTH bits of the XOR, top and bottom bits set.
    function automatic logic [WIDTH-1:0] shape(input logic [31:0] a, input logic [31:0] b);
        longint unsigned x;
        x = longint'(a ^ b) % (64'd1 << WIDTH);
        x = x | (64'd1 << (WIDTH - 1)) | 64'd1;
        return x[WIDTH-1:0];
    endfunction

    // Transaction model: a pending transaction is due for its second sample
    // at a given absolute edge number.
    int               edge_n = 0;
    logic             m_en, m_seeded, m_busy, m_valid;
    logic [WIDTH-1:0] m_cand, m_prev;
    logic [31:0]      m_s1;
    int               m_due;

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_en <= 1'b0; m_seeded <= 1'b0; m_busy <= 1'b0; m_valid <= 1'b0;
            m_cand <= '0; m_prev <= '0; m_s1 <= '0; m_due <= 0;
        end else begin
            m_en <= 1'b1;
            if (start) m_seeded <= 1'b1;
            if (!m_busy) begin
                if (req && m_seeded) begin
                    m_busy <= 1'b1;
                    m_s1   <= rng_in;
                    m_due  <= edge_n + GAP;
                end
            end else if (!m_valid) begin
                if (edge_n == m_due) begin
                    if (reject_dup && shape(m_s1, rng_in) == m_prev) begin
                        m_s1  <= rng_in;
                        m_due <= edge_n + GAP;
                    end else begin
                        m_cand  <= shape(m_s1, rng_in);
                        m_valid <= 1'b1;
                    end
                end
            end else if (cand_ready) begin
                m_prev  <= m_cand;
                m_valid <= 1'b0;
                m_busy  <= 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        check("cmp_lfsr_en", lfsr_en, m_en);
        check("cmp_seeded", seeded, m_seeded);
        check("cmp_busy", busy, m_busy);
        check("cmp_cand_valid", cand_valid, m_valid);
        check("cmp_cand", cand, m_cand);
    end

    // Capture a at edge k, present b at edge k+GAP; returns after edge k+GAP.
    task automatic run_pair(input logic [31:0] a, input logic [31:0] b);
        rng_in = a;
        req    = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check("capture_busy", busy, 1);
        rng_in = 32'h5A5A_C3C3;
        for (int i = 1; i < GAP; i++) begin
            @(negedge clk);
            check("wait_busy", busy, 1);
            check("wait_no_valid", cand_valid, 0);
        end
        rng_in = b;
        @(negedge clk);
        rng_in = 32'h1357_9BDF;
    endtask

    task automatic accept();
        cand_ready = 1'b1;
        @(negedge clk);
        cand_ready = 1'b0;
        check("accept_valid_low", cand_valid, 0);
        check("accept_idle", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and seed gating
        repeat (3) @(negedge clk);
        check("rst_lfsr_en", lfsr_en, 0);
        check("rst_seeded", seeded, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", cand_valid, 0);
        check("rst_cand", cand, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("lfsr_en_after_rst", lfsr_en, 1);
        req = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("unseeded_busy", busy, 0);
            check("unseeded_valid", cand_valid, 0);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("seeded_set", seeded, 1);
        check("seeded_not_yet_busy", busy, 0);

        // Nominal: 0x1234 ^ 0xFF00 -> 0xED35, then backpressure
        run_pair(32'h0000_1234, 32'h0000_FF00);
        check("nominal_valid", cand_valid, 1);
        check("nominal_cand", cand, 16'hED35);
        cand_ready = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("bp_cand", cand, 16'hED35);
            check("bp_valid", cand_valid, 1);
        end
        accept();
        check("accept_cand_kept", cand, 16'hED35);

        // Duplicate rejection: resample at k+4, second sample 0x0F0F at k+8 -> 0xF00F
        reject_dup = 1'b1;
        run_pair(32'h0000_1234, 32'h0000_FF00);
        check("dup_no_valid", cand_valid, 0);
        check("dup_busy", busy, 1);
        for (int i = 1; i < GAP; i++) begin
            @(negedge clk);
            check("dup_wait_no_valid", cand_valid, 0);
        end
        rng_in = 32'h0000_0F0F;
        @(negedge clk);
        check("dup_resample_valid", cand_valid, 1);
        check("dup_resample_cand", cand, 16'hF00F);
        accept();

        // Shaping: identical samples give 0x8001
        reject_dup = 1'b0;
        run_pair(32'h0000_ABCD, 32'h0000_ABCD);
        check("shape_cand", cand, 16'h8001);
        accept();

        // Repeat of ED35 accepted when reject_dup is low
        run_pair(32'h0000_1234, 32'h0000_FF00);
        accept();
        run_pair(32'h0000_1234, 32'h0000_FF00);
        check("nodup_valid", cand_valid, 1);
        check("nodup_cand", cand, 16'hED35);

        // No capture on the acceptance edge even with req high
        req        = 1'b1;
        cand_ready = 1'b1;
        @(negedge clk);
        cand_ready = 1'b0;
        check("accept_edge_no_capture", busy, 0);
        rng_in = 32'h0000_2222;
        @(negedge clk);
        check("capture_after_accept", busy, 1);
        req = 1'b0;
        @(negedge clk);

        // Asynchronous reset mid-WAIT (cnt=2)
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_seeded", seeded, 0);
        check("midrst_lfsr_en", lfsr_en, 0);
        check("midrst_valid", cand_valid, 0);
        check("midrst_cand", cand, 0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("postrst_busy", busy, 0);
            check("postrst_seeded", seeded, 0);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("reseed", seeded, 1);
        rng_in = 32'h0000_0F0F;
        @(negedge clk);
        req = 1'b0;
        check("reseed_capture", busy, 1);
        rng_in = 32'h0000_00F0;
        repeat (GAP + 2) @(negedge clk);
        check("final_valid", cand_valid, 1);
        accept();
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rng_candidate_sampler.md
Name: rng_candidate_sampler

Overview:
- Consumer side of the 32-bit free-running LFSR used for key generation.
- Drives the LFSR enable and gates sampling until the user's start press has seeded the timing entropy.
- On request from the key-generation FSM, it takes two LFSR words GAP cycles apart, XOR-whitens them and shapes the result into an odd, full-width WIDTH-bit prime candidate.
- It presents the candidate over a valid/ready handshake and can reject a repeat of the previously accepted candidate, so that p differs from q.

Parameters:
- WIDTH, 16, candidate width in bits; legal range 2..32.
- GAP, 4, cycles between first and second LFSR sample; legal range 1..255.

Ports:
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle, already-synchronized start pulse from the user button
- rng_in  in  32  current LFSR output word
- lfsr_en  out  1  LFSR advance enable
- seeded  out  1  high once start has been seen since reset
- req  in  1  level request for a new candidate from the key-gen FSM
- reject_dup  in  1  when high, a candidate equal to the last accepted one is discarded
- cand  out  WIDTH  candidate value
- cand_valid  out  1  candidate available
- cand_ready  in  1  consumer accepts candidate
- busy  out  1  high in WAIT or VALID

Behaviour:
- Reset is asynchronous and active-low: rst_n=0 immediately forces all of the following to 0:
  - outputs: lfsr_en, seeded, cand, cand_valid, busy
  - internal state: s1, cnt, prev (prev has no valid flag, so prev=0)
  - state register: IDLE
- lfsr_en goes to 1 on the first clk edge after rst_n deasserts and stays 1 (free-running).
- seeded is set on any clk edge with start=1 and is sticky until reset. start is otherwise ignored in every state.
- States are IDLE, WAIT and VALID.
- IDLE:
  - On an edge with req=1 and seeded=1: capture s1<=rng_in, set cnt<=GAP-1, go to WAIT.
  - If req=1 and seeded=0: remain in IDLE; the request is held pending by the level of req.
- WAIT:
  - On an edge with cnt!=0: cnt<=cnt-1.
  - On an edge with cnt==0: compute w=(s1^rng_in)[WIDTH-1:0], then nc={1'b1, w[WIDTH-2:1], 1'b1}. For WIDTH=2, nc=2'b11.
  - If reject_dup=1 and nc==prev: resample, i.e. s1<=rng_in, cnt<=GAP-1, stay in WAIT. There is no retry limit.
  - Otherwise: cand<=nc, cand_valid<=1, go to VALID.
- Timing: with the first capture at edge k, the second sample is taken at edge k+GAP and cand_valid is high after edge k+GAP. Each dup rejection adds GAP cycles.
- VALID:
  - cand and cand_valid are held stable while cand_ready=0.
  - On an edge with cand_ready=1: prev<=cand, cand_valid<=0, go to IDLE. cand keeps its value.
  - A new capture may not begin on the same edge as the acceptance; the earliest next capture is the following edge.
- req deasserted in WAIT or VALID does not abort the transaction; it completes normally.
- cand_ready is ignored outside VALID.
- busy=1 exactly in WAIT and VALID.
- Reset mid-operation returns every register to its reset value.
- reject_dup is sampled only at the WAIT edge where cnt==0.

Test Plan:
- Reset/seed: hold rst_n=0 and check all outputs are 0. Release rst_n and check lfsr_en=1 after one edge. Drive req=1 with no start for 20 cycles and check busy=0, cand_valid=0. Pulse start and check seeded=1 and that capture occurs on the next edge.
- Nominal, WIDTH=16, GAP=4: rng_in=0x00001234 at capture edge k, rng_in=0x0000FF00 at edge k+4. Check cand=0xED35 and cand_valid=1 after edge k+4, and busy=1 over edges k+1..k+4.
- Shaping: both samples equal, so the XOR is 0. Check cand=0x8001.
- Backpressure: hold cand_ready=0 for 10 cycles and check cand stays 0xED35 with cand_valid held. Raise cand_ready and check cand_valid=0 on the next edge and return to IDLE.
- Duplicate rejection: with prev=0xED35 and reject_dup=1, repeat the nominal stimulus. Check no cand_valid at edge k+4 and a resample with cand_valid at edge k+8 giving a new value. Repeat with reject_dup=0 and check 0xED35 is accepted at edge k+4.
- Reset mid-WAIT: pull rst_n low asynchronously between edges at cnt=2. Check busy, seeded and lfsr_en drop to 0 immediately. After release, check req is ignored until a new start pulse.
